// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider.
// Holds the divider FSM state encoding and the default operand width.
package div_radix2_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } divState_e;

endpackage

// File: rtl/div_radix2_step.sv
// Single combinational restoring-division iteration.
// remQuo_i   : {partial remainder, remaining dividend / quotient bits so far}
// divisor_i  : divisor magnitude
// remQuo_o   : pair after shifting one dividend bit into the remainder,
//              trial-subtracting the divisor and shifting in the quotient bit
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] remQuo_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] remQuo_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;

    // The shifted remainder needs one extra bit; since the remainder is
    // always below the divisor, the difference fits and its MSB is the sign.
    assign partial = remQuo_i[2*WIDTH-1:WIDTH-1];
    assign trial   = partial - {1'b0, divisor_i};

    always_comb begin
        remQuo_o = {partial[WIDTH-1:0], remQuo_i[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            remQuo_o = {trial[WIDTH-1:0], remQuo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start             DIV/DIVU occupies EX (level, held while EX is stalled)
//   signed_div        1 = DIV (two's complement), 0 = DIVU
//   a, b              dividend and divisor after forwarding
//   annul             EX flush; aborts any operation
//   hold              external EX freeze; a finished result waits in DONE
//   stall_div         request to freeze F/D/E while the divide is running
//   ready             result valid this cycle
//   result            {remainder, quotient}
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    input  logic               hold,
    output logic               stall_div,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    divState_e          state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] remQuo_q, remQuo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               negQuo_q, negQuo_d;
    logic               negRem_q, negRem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               signA, signB;
    logic [WIDTH-1:0]   absA, absB;
    logic [2*WIDTH-1:0] stepOut;
    logic [WIDTH-1:0]   fixQuo, fixRem;

    // Operands only count as negative for DIV; DIVU treats them as magnitudes.
    assign signA = signed_div & a[WIDTH-1];
    assign signB = signed_div & b[WIDTH-1];
    assign absA  = signA ? -a : a;
    assign absB  = signB ? -b : b;

    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .remQuo_i (remQuo_q),
        .divisor_i(divisor_q),
        .remQuo_o (stepOut)
    );

    // Sign fix-up on the final iteration's output: quotient negative when
    // the operand signs differ, remainder follows the dividend.
    assign fixQuo = negQuo_q ? -stepOut[WIDTH-1:0] : stepOut[WIDTH-1:0];
    assign fixRem = negRem_q ? -stepOut[2*WIDTH-1:WIDTH] : stepOut[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            remQuo_q  <= '0;
            divisor_q <= '0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            remQuo_q  <= remQuo_d;
            divisor_q <= divisor_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
            result_q  <= result_d;
        end
    end

    // A dropped start while BUSY/DONE means EX was flushed under us, so it
    // aborts exactly like annul. Divide-by-zero skips BUSY entirely.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        remQuo_d  = remQuo_q;
        divisor_d = divisor_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;
        result_d  = result_q;
        stall_div = 1'b0;
        ready     = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                stall_div = start & ~annul;
                if (start && !annul) begin
                    remQuo_d  = {{WIDTH{1'b0}}, absA};
                    divisor_d = absB;
                    negQuo_d  = signA ^ signB;
                    negRem_d  = signA;
                    count_d   = '0;
                    if (b == '0) begin
                        result_d = {a, {WIDTH{1'b1}}};
                        state_d  = DIV_DONE;
                    end else begin
                        state_d  = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                stall_div = ~annul;
                if (annul || !start) begin
                    state_d = DIV_IDLE;
                end else begin
                    remQuo_d = stepOut;
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        result_d = {fixRem, fixQuo};
                        state_d  = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                ready = ~annul;
                if (annul || !start || !hold) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign result = result_q;

endmodule
